// File: rtl/bram32_lsu_pkg.sv
// ============================================================================
//  Module      : bram32_lsu_pkg
//  Description : Shared types and constants for the BRAM32 load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram32_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    localparam logic [2:0] SUB_WORD  = 3'd1;
    localparam logic [2:0] SUB_HALF0 = 3'd2;
    localparam logic [2:0] SUB_BYTE0 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/bram32_load_align.sv
// ============================================================================
//  Module      : bram32_load_align
//  Description : Selects the addressed lane of a BRAM word and zero/sign
//                extends it to a 32-bit load result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram32_load_align
    import bram32_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_rdata[{i_offset, 3'b000} +: 8];
        w_half   = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bram32_lsu.sv
// ============================================================================
//  Module      : bram32_lsu
//  Description : Single-outstanding load/store initiator for a 32-bit
//                byte-lane BRAM port. Define BRAM32_LSU_FAST_RSP_EN for a
//                1-cycle response with combinational load alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram32_lsu
    import bram32_lsu_pkg::*;
#(
    parameter  int DEPTH      = 512,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH+1:0] i_req_addr,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_mem_we,
    output logic [2:0]            o_mem_wr_subaddr,
    input  logic [31:0]           i_mem_rdata
);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_off;
    size_e                 r_size;
    logic                  r_uns;
    logic                  r_we;
    logic                  r_err;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;

    size_e                 w_size;
    logic                  w_err;
    logic                  w_accept;
    logic [31:0]           w_load;

    assign w_size      = size_e'(i_req_size);
    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign w_accept    = i_req_valid && o_req_ready;
    assign o_mem_we    = w_accept && i_req_we && !w_err;
    assign o_mem_addr  = (r_state == ST_IDLE) ? i_req_addr[ADDR_WIDTH+1:2] : r_addr;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;

    always_comb begin
        case (w_size)
            SZ_HALF: w_err = i_req_addr[0];
            SZ_WORD: w_err = |i_req_addr[1:0];
            SZ_BYTE: w_err = 1'b0;
            default: w_err = 1'b1;
        endcase
    end

    // Lanes are replicated so the BRAM's sub-address alone picks the bytes.
    always_comb begin
        case (w_size)
            SZ_WORD: begin
                o_mem_wr_subaddr = SUB_WORD;
                o_mem_wdata      = i_req_wdata;
            end
            SZ_HALF: begin
                o_mem_wr_subaddr = SUB_HALF0 + {2'b00, i_req_addr[1]};
                o_mem_wdata      = {2{i_req_wdata[15:0]}};
            end
            default: begin
                o_mem_wr_subaddr = SUB_BYTE0 + {1'b0, i_req_addr[1:0]};
                o_mem_wdata      = {4{i_req_wdata[7:0]}};
            end
        endcase
    end

    bram32_load_align u_align (
        .i_rdata    (i_mem_rdata),
        .i_offset   (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_result   (w_load)
    );

`ifdef BRAM32_LSU_FAST_RSP_EN
    // BRAM address is held in RESP, so its output stays valid under backpressure.
    assign o_rsp_rdata = (r_rsp_valid && !r_we && !r_err) ? w_load : 32'd0;
`else
    logic [31:0] r_rsp_rdata;
    assign o_rsp_rdata = r_rsp_rdata;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_off       <= 2'd0;
            r_size      <= SZ_BYTE;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
`ifndef BRAM32_LSU_FAST_RSP_EN
            r_rsp_rdata <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr <= i_req_addr[ADDR_WIDTH+1:2];
                        r_off  <= i_req_addr[1:0];
                        r_size <= w_size;
                        r_uns  <= i_req_unsigned;
                        r_we   <= i_req_we;
                        r_err  <= w_err;
`ifdef BRAM32_LSU_FAST_RSP_EN
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
`else
                        r_state     <= ST_CAPTURE;
`endif
                    end
                end
`ifndef BRAM32_LSU_FAST_RSP_EN
                ST_CAPTURE: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err;
                    r_rsp_rdata <= (r_we || r_err) ? 32'd0 : w_load;
                end
`endif
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
`ifndef BRAM32_LSU_FAST_RSP_EN
                        r_rsp_rdata <= 32'd0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram32_lsu.sv
// ============================================================================
//  Module      : tb_bram32_lsu
//  Description : Directed self-checking bench for bram32_lsu with a
//                behavioural byte-lane BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram32_lsu;

`ifdef BRAM32_LSU_FAST_RSP_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_uns;
    logic [10:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we;
    logic [2:0]  mem_sub;

    int errors = 0;
    int checks = 0;

    logic [31:0] bram [512];

    always #5 clk = ~clk;

    bram32_lsu #(.DEPTH(512)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_addr       (req_addr),
        .i_req_we         (req_we),
        .i_req_size       (req_size),
        .i_req_unsigned   (req_uns),
        .i_req_wdata      (req_wdata),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_rdata      (rsp_rdata),
        .o_rsp_err        (rsp_err),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .o_mem_we         (mem_we),
        .o_mem_wr_subaddr (mem_sub),
        .i_mem_rdata      (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_sub)
                3'd1: bram[mem_addr]        <= mem_wdata;
                3'd2: bram[mem_addr][15:0]  <= mem_wdata[15:0];
                3'd3: bram[mem_addr][31:16] <= mem_wdata[31:16];
                3'd4: bram[mem_addr][7:0]   <= mem_wdata[7:0];
                3'd5: bram[mem_addr][15:8]  <= mem_wdata[15:8];
                3'd6: bram[mem_addr][23:16] <= mem_wdata[23:16];
                3'd7: bram[mem_addr][31:24] <= mem_wdata[31:24];
                default: ;
            endcase
        end
        mem_rdata <= bram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [10:0] addr, input logic [31:0] wd,
                        input logic [2:0] exp_sub, input logic [31:0] exp_wd,
                        input logic exp_we, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_addr", {23'd0, mem_addr}, {23'd0, addr[10:2]});
        if (exp_we) begin
            chk("mem_sub", {29'd0, mem_sub}, {29'd0, exp_sub});
            chk("mem_wdata", mem_wdata, exp_wd);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("we_after", {31'd0, mem_we}, 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, EXP_LAT);
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("retire_valid", {31'd0, rsp_valid}, 32'd0);
        chk("retire_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) bram[i] = 32'd0;
        rst = 1'b1; rsp_ready = 1'b0;
        // A store presented during reset must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0;
        req_addr = 11'h010; req_wdata = 32'h5555_5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0; rst = 1'b0;

        // we sz uns addr wdata sub exp_wd exp_we rdata err hold
        xfer(1, 2, 0, 11'h010, 32'hDEAD_BEEF, 3'd1, 32'hDEAD_BEEF, 1, 32'h0, 0, 0);
        xfer(0, 2, 0, 11'h010, 32'h0, 3'd0, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
        xfer(1, 0, 0, 11'h013, 32'h0000_00A5, 3'd7, 32'hA5A5_A5A5, 1, 32'h0, 0, 0);
        xfer(0, 0, 0, 11'h013, 32'h0, 3'd0, 32'h0, 0, 32'hFFFF_FFA5, 0, 0);
        xfer(0, 0, 1, 11'h013, 32'h0, 3'd0, 32'h0, 0, 32'h0000_00A5, 0, 0);
        xfer(0, 2, 0, 11'h010, 32'h0, 3'd0, 32'h0, 0, 32'hA5AD_BEEF, 0, 0);
        xfer(0, 0, 0, 11'h010, 32'h0, 3'd0, 32'h0, 0, 32'hFFFF_FFEF, 0, 0);
        xfer(0, 1, 1, 11'h010, 32'h0, 3'd0, 32'h0, 0, 32'h0000_BEEF, 0, 0);
        xfer(1, 1, 0, 11'h022, 32'h1234_8001, 3'd3, 32'h8001_8001, 1, 32'h0, 0, 0);
        xfer(0, 1, 0, 11'h022, 32'h0, 3'd0, 32'h0, 0, 32'hFFFF_8001, 0, 0);
        xfer(0, 1, 1, 11'h022, 32'h0, 3'd0, 32'h0, 0, 32'h0000_8001, 0, 0);
        // Misaligned and illegal-size requests: error, no write.
        xfer(0, 2, 0, 11'h011, 32'h0, 3'd0, 32'h0, 0, 32'h0, 1, 0);
        xfer(1, 1, 0, 11'h021, 32'h0000_FFFF, 3'd0, 32'h0, 0, 32'h0, 1, 0);
        xfer(1, 3, 0, 11'h020, 32'hFFFF_FFFF, 3'd0, 32'h0, 0, 32'h0, 1, 0);
        xfer(0, 2, 0, 11'h020, 32'h0, 3'd0, 32'h0, 0, 32'h8001_0000, 0, 0);
        // Backpressure for five cycles.
        xfer(0, 2, 0, 11'h010, 32'h0, 3'd0, 32'h0, 0, 32'hA5AD_BEEF, 0, 5);

        // Reset one cycle after a load is accepted.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 11'h010;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("rstcap_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0; #1;
        chk("rstcap_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the accept cycle of a store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 11'h010;
        req_wdata = 32'h1111_1111; rst = 1'b1; #1;
        chk("rstacc_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        chk("rstacc_valid", {31'd0, rsp_valid}, 32'd0);
        xfer(0, 2, 0, 11'h010, 32'h0, 3'd0, 32'h0, 0, 32'hA5AD_BEEF, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
